// File: rtl/llc_set_table.sv
`timescale 1ns/1ps
// Purpose : in-flight set table between the LLC lookup and update stages. It stalls any
//           request whose set index is already in flight.
// Latency : grant, pointer and conflict are combinational from registered state (zero-cycle
//           grant). A new entry is seen by the conflict check starting on the next cycle.
// Backpr. : alloc_ready_out stays low while the table is full or the set conflicts. Upstream
//           holds its request. A removal frees space one cycle after it is presented.
// Ports   : clk/rst                 - clock, synchronous active-high reset
//           alloc_valid_in/_set_in  - request and its set; alloc_ready_out/alloc_ptr_out grant it
//           conflict_out            - request set matches a valid entry
//           remove_set_from_table / table_pointer_to_remove - update stage retires an entry
//           full_out/empty_out/occupancy_out - fill status; remove_err_out - sticky bad remove
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 8
`endif

module llc_set_table #(
  parameter int TABLE_DEPTH = 8,
  parameter int SET_W       = `LLC_SET_BITS,
  localparam int PTR_W      = $clog2(TABLE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid_in,
  input  logic [SET_W-1:0] alloc_set_in,
  output logic             alloc_ready_out,
  output logic [PTR_W-1:0] alloc_ptr_out,
  output logic             conflict_out,
  input  logic             remove_set_from_table,
  input  logic [PTR_W-1:0] table_pointer_to_remove,
  output logic             full_out,
  output logic             empty_out,
  output logic [PTR_W:0]   occupancy_out,
  output logic             remove_err_out
);

  logic [TABLE_DEPTH-1:0] valid_q;
  logic [SET_W-1:0]       set_q [TABLE_DEPTH];
  logic [PTR_W:0]         occ_q;
  logic                   err_q;

  logic conflict;
  logic free_found;
  logic [PTR_W-1:0] free_ptr;
  logic alloc_fire;
  logic remove_hit;
  logic remove_miss;

  // Conflict and free-slot search look only at registered state. A same-cycle removal
  // therefore never frees space or clears a conflict until the following cycle.
  always_comb begin
    conflict   = 1'b0;
    free_found = 1'b0;
    free_ptr   = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (alloc_valid_in && valid_q[i] && (set_q[i] == alloc_set_in)) begin
        conflict = 1'b1;
      end
      if (!valid_q[i] && !free_found) begin
        free_ptr   = PTR_W'(i);
        free_found = 1'b1;
      end
    end
  end

  assign full_out        = (occ_q == (PTR_W+1)'(TABLE_DEPTH));
  assign empty_out       = (occ_q == '0);
  assign occupancy_out   = occ_q;
  assign remove_err_out  = err_q;
  assign conflict_out    = conflict;
  assign alloc_ptr_out   = free_ptr;
  assign alloc_ready_out = alloc_valid_in && !full_out && !conflict;

  assign alloc_fire  = alloc_valid_in && alloc_ready_out;
  assign remove_hit  = remove_set_from_table && valid_q[table_pointer_to_remove];
  assign remove_miss = remove_set_from_table && !valid_q[table_pointer_to_remove];

  // The alloc target is always a free slot, so it can never collide with a valid remove target.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        set_q[i] <= '0;
      end
    end else begin
      if (remove_hit) begin
        valid_q[table_pointer_to_remove] <= 1'b0;
      end
      if (remove_miss) begin
        err_q <= 1'b1;
      end
      if (alloc_fire) begin
        valid_q[free_ptr] <= 1'b1;
        set_q[free_ptr]   <= alloc_set_in;
      end
      case ({alloc_fire, remove_hit})
        2'b10:   occ_q <= occ_q + (PTR_W+1)'(1);
        2'b01:   occ_q <= occ_q - (PTR_W+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_set_table.sv
`timescale 1ns/1ps
module tb_llc_set_table;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid_in;
  logic [7:0] alloc_set_in;
  logic       alloc_ready_out;
  logic [2:0] alloc_ptr_out;
  logic       conflict_out;
  logic       remove_set_from_table;
  logic [2:0] table_pointer_to_remove;
  logic       full_out;
  logic       empty_out;
  logic [3:0] occupancy_out;
  logic       remove_err_out;

  always #5 clk = ~clk;

  llc_set_table #(.TABLE_DEPTH(8), .SET_W(8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .alloc_valid_in          (alloc_valid_in),
    .alloc_set_in            (alloc_set_in),
    .alloc_ready_out         (alloc_ready_out),
    .alloc_ptr_out           (alloc_ptr_out),
    .conflict_out            (conflict_out),
    .remove_set_from_table   (remove_set_from_table),
    .table_pointer_to_remove (table_pointer_to_remove),
    .full_out                (full_out),
    .empty_out               (empty_out),
    .occupancy_out           (occupancy_out),
    .remove_err_out          (remove_err_out)
  );

  typedef struct packed {
    logic       rdy;
    logic [2:0] ptr;
    logic       conf;
    logic       full;
    logic       empty;
    logic [3:0] occ;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the set of in-flight entries as plain arrays.
  bit         mvalid [8];
  logic [7:0] mset   [8];
  bit         merr;
  bit         granted;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mset[i]   = '0;
    end
    merr = 1'b0;
  endfunction

  // Monitor: each sampled cycle with a pending expectation is compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready",    32'(alloc_ready_out), 32'(e.rdy));
        chk("conflict", 32'(conflict_out),    32'(e.conf));
        if (e.rdy) chk("ptr", 32'(alloc_ptr_out), 32'(e.ptr));
        chk("full",     32'(full_out),        32'(e.full));
        chk("empty",    32'(empty_out),       32'(e.empty));
        chk("occ",      32'(occupancy_out),   32'(e.occ));
        chk("rm_err",   32'(remove_err_out),  32'(e.err));
      end
    end
  end

  // One clock of stimulus: drive, predict, push, then advance the model past the edge.
  task automatic cycle(input bit av, input logic [7:0] s, input bit rv, input logic [2:0] rp);
    exp_t e;
    int   n;
    int   fp;
    bit   conf;
    alloc_valid_in          = av;
    alloc_set_in            = s;
    remove_set_from_table   = rv;
    table_pointer_to_remove = rp;
    n = 0;
    fp = -1;
    conf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mvalid[i]) n++;
      if (av && mvalid[i] && mset[i] == s) conf = 1'b1;
      if (!mvalid[i] && fp < 0) fp = i;
    end
    e.conf  = conf;
    e.full  = (n == 8);
    e.empty = (n == 0);
    e.occ   = 4'(n);
    e.ptr   = (fp < 0) ? 3'd0 : 3'(fp);
    e.rdy   = av && (n < 8) && !conf;
    e.err   = merr;
    q.push_back(e);
    granted = e.rdy;
    @(posedge clk);
    if (rv) begin
      if (mvalid[rp]) mvalid[rp] = 1'b0;
      else merr = 1'b1;
    end
    if (e.rdy) begin
      mvalid[fp] = 1'b1;
      mset[fp]   = s;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid_in = 1'b0;
    remove_set_from_table = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit         pend;
    logic [7:0] ps;
    int         vl[$];
    bit         rv;
    logic [2:0] rp;

    rst = 1'b1;
    alloc_valid_in = 1'b0;
    alloc_set_in = '0;
    remove_set_from_table = 1'b0;
    table_pointer_to_remove = '0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state, first alloc, conflict on repeat.
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h12, 0, 0);
    cycle(1, 8'h12, 0, 0);
    cycle(0, 8'h00, 0, 0);

    // Fill, refuse when full, remove frees pointer 3.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 8'(i), 0, 0);
    cycle(1, 8'h20, 0, 0);
    cycle(0, 8'h00, 1, 3);
    cycle(1, 8'h20, 0, 0);

    // Full table: same-cycle remove does not free space.
    cycle(1, 8'h30, 1, 5);
    cycle(1, 8'h30, 0, 0);
    cycle(0, 8'h00, 0, 0);

    // Same-set remove plus alloc stalls one cycle.
    do_reset();
    cycle(1, 8'h40, 0, 0);
    cycle(1, 8'h41, 0, 0);
    cycle(1, 8'h44, 0, 0);
    cycle(1, 8'h43, 0, 0);
    cycle(1, 8'h44, 1, 2);
    cycle(1, 8'h44, 0, 0);
    cycle(0, 8'h00, 0, 0);

    // Remove of an invalid entry is sticky.
    cycle(0, 8'h00, 1, 6);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);

    // Reset mid-operation discards entries and clears the error.
    for (int i = 0; i < 5; i++) cycle(1, 8'(i + 1), 0, 0);
    do_reset();
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h02, 0, 0);
    cycle(0, 8'h00, 1, 4);
    cycle(0, 8'h00, 0, 0);

    // Randomized traffic; requests are held until granted.
    do_reset();
    pend = 1'b0;
    ps = '0;
    for (int k = 0; k < 600; k++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        ps = 8'($urandom_range(0, 11));
      end
      vl.delete();
      for (int i = 0; i < 8; i++) if (mvalid[i]) vl.push_back(i);
      rv = ($urandom_range(0, 2) == 0);
      if (vl.size() == 0 || $urandom_range(0, 15) == 0) rp = 3'($urandom_range(0, 7));
      else rp = 3'(vl[$urandom_range(0, vl.size() - 1)]);
      cycle(pend, ps, rv, rp);
      if (granted) pend = 1'b0;
    end
    cycle(0, 8'h00, 0, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
